// File: rtl/ras_pkg.sv
// Shared decode constants and types for the return-address shadow stack.
package ras_pkg;

    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [4:0] REG_RA  = 5'd1;
    localparam logic [4:0] REG_T0  = 5'd5;

    typedef enum logic {RAS_IDLE, RAS_REFILL} ras_state_e;

    function automatic logic is_link(input logic [4:0] r);
        return (r == REG_RA) || (r == REG_T0);
    endfunction

endpackage

// File: rtl/ras_ram.sv
// Simple dual-port storage for the stacked return addresses below the top
// entry: one write port, one registered read port.
module ras_ram #(
    parameter int ENTRIES = 15,
    parameter int AW      = 32,
    parameter int PW      = 4
) (
    input  logic          clk,
    input  logic          we,
    input  logic [PW-1:0] waddr,
    input  logic [AW-1:0] wdata,
    input  logic          re,
    input  logic [PW-1:0] raddr,
    output logic [AW-1:0] rdata
);

    logic [AW-1:0] mem [ENTRIES];
    logic [AW-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata_q <= mem[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/ra_shadow_stack.sv
// Shadow return-address stack: tracks call/return pairs leaving IF_ID and
// raises sticky mismatch/overflow/underflow flags for the CSR trap logic.
module ra_shadow_stack
    import ras_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = 32
) (
    input  logic                   clk,
    input  logic                   Rst_n,
    input  logic                   id_adv,
    input  logic                   branch,
    input  logic [31:0]            ins,
    input  logic [AW-1:0]          next_addr,
    input  logic [AW-1:0]          branoff,
    input  logic                   ras_clr,
    output logic                   RAS_rdy,
    output logic                   ras_mismatch,
    output logic                   ras_mismatch_p,
    output logic                   ras_overflow,
    output logic                   ras_underflow,
    output logic [$clog2(DEPTH):0] ras_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [PW-1:0] WP_MAX   = PW'(DEPTH - 2);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    ras_state_e    state_q, state_d;
    logic [AW-1:0] tos_q, tos_d;
    logic [PW-1:0] wp_q, wp_d, wp_inc, wp_dec;
    logic [CW-1:0] count_q, count_d;
    logic          mismatch_q, mismatch_d;
    logic          mismatch_p_q, mismatch_p_d;
    logic          overflow_q, overflow_d;
    logic          underflow_q, underflow_d;
    logic          ram_we, ram_re;
    logic [AW-1:0] ram_rdata;

    logic [6:0] opcode;
    logic [4:0] rd, rs1;
    logic       is_jal, is_jalr, is_call, is_ret, is_swap, fire;
    logic       unused_ins_bits;

    assign opcode          = ins[6:0];
    assign rd              = ins[11:7];
    assign rs1             = ins[19:15];
    assign unused_ins_bits = ^{ins[31:20], ins[14:12]};

    assign is_jal  = (opcode == OP_JAL);
    assign is_jalr = (opcode == OP_JALR);
    assign is_call = (is_jal | is_jalr) & is_link(rd);
    assign is_ret  = is_jalr & (rd == 5'd0) & is_link(rs1);
    // Coroutine hint: jalr with two different link registers pops then pushes.
    assign is_swap = is_jalr & is_link(rd) & is_link(rs1) & (rd != rs1);
    assign fire    = id_adv & branch & (state_q == RAS_IDLE);

    // The RAM holds DEPTH-1 entries, so the pointer wraps at DEPTH-2.
    assign wp_inc = (wp_q == WP_MAX) ? '0 : wp_q + 1'b1;
    assign wp_dec = (wp_q == '0) ? WP_MAX : wp_q - 1'b1;

    ras_ram #(
        .ENTRIES(DEPTH - 1),
        .AW     (AW),
        .PW     (PW)
    ) u_ram (
        .clk  (clk),
        .we   (ram_we),
        .waddr(wp_q),
        .wdata(tos_q),
        .re   (ram_re),
        .raddr(wp_dec),
        .rdata(ram_rdata)
    );

    always_comb begin
        state_d      = state_q;
        tos_d        = tos_q;
        wp_d         = wp_q;
        count_d      = count_q;
        mismatch_d   = mismatch_q;
        mismatch_p_d = 1'b0;
        overflow_d   = overflow_q;
        underflow_d  = underflow_q;
        ram_we       = 1'b0;
        ram_re       = 1'b0;

        if (ras_clr) begin
            count_d     = '0;
            wp_d        = '0;
            mismatch_d  = 1'b0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
            state_d     = RAS_IDLE;
        end else if (state_q == RAS_REFILL) begin
            tos_d   = ram_rdata;
            state_d = RAS_IDLE;
        end else if (fire && is_call && !is_swap) begin
            tos_d = next_addr;
            if (count_q != '0) begin
                ram_we = 1'b1;
                wp_d   = wp_inc;
            end
            // At full the wrap silently overwrites the oldest entry.
            if (count_q != CNT_FULL) begin
                count_d = count_q + 1'b1;
            end else begin
                overflow_d = 1'b1;
            end
        end else if (fire && (is_ret || is_swap)) begin
            if (count_q == '0) begin
                underflow_d = 1'b1;
                if (is_swap) begin
                    tos_d   = next_addr;
                    count_d = CW'(1);
                end
            end else begin
                if (branoff != tos_q) begin
                    mismatch_d   = 1'b1;
                    mismatch_p_d = 1'b1;
                end
                if (is_swap) begin
                    tos_d = next_addr;
                end else begin
                    count_d = count_q - 1'b1;
                    if (count_q > CW'(1)) begin
                        ram_re  = 1'b1;
                        wp_d    = wp_dec;
                        state_d = RAS_REFILL;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q      <= RAS_IDLE;
            tos_q        <= '0;
            wp_q         <= '0;
            count_q      <= '0;
            mismatch_q   <= 1'b0;
            mismatch_p_q <= 1'b0;
            overflow_q   <= 1'b0;
            underflow_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            tos_q        <= tos_d;
            wp_q         <= wp_d;
            count_q      <= count_d;
            mismatch_q   <= mismatch_d;
            mismatch_p_q <= mismatch_p_d;
            overflow_q   <= overflow_d;
            underflow_q  <= underflow_d;
        end
    end

    assign RAS_rdy        = (state_q == RAS_IDLE);
    assign ras_mismatch   = mismatch_q;
    assign ras_mismatch_p = mismatch_p_q;
    assign ras_overflow   = overflow_q;
    assign ras_underflow  = underflow_q;
    assign ras_count      = count_q;

endmodule

// File: tb/tb_ra_shadow_stack.sv
// Directed bench for ra_shadow_stack: a queue-based model is compared with the
// DUT every cycle, plus hand-computed expectations at key points.
module tb_ra_shadow_stack;

    localparam int DEPTH = 16;
    localparam int AW    = 32;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic          clk;
    logic          Rst_n = 1'b0;
    logic          id_adv = 1'b0;
    logic          branch = 1'b0;
    logic [31:0]   ins = NOP;
    logic [AW-1:0] next_addr = '0;
    logic [AW-1:0] branoff = '0;
    logic          ras_clr = 1'b0;
    logic          RAS_rdy;
    logic          ras_mismatch, ras_mismatch_p, ras_overflow, ras_underflow;
    logic [4:0]    ras_count;

    int checkCount = 0;
    int errorCount = 0;

    logic [31:0] mq[$];
    logic        mRdy = 1'b1;
    logic        mMis = 1'b0;
    logic        mMisP = 1'b0;
    logic        mOvf = 1'b0;
    logic        mUnd = 1'b0;

    ra_shadow_stack #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk           (clk),
        .Rst_n         (Rst_n),
        .id_adv        (id_adv),
        .branch        (branch),
        .ins           (ins),
        .next_addr     (next_addr),
        .branoff       (branoff),
        .ras_clr       (ras_clr),
        .RAS_rdy       (RAS_rdy),
        .ras_mismatch  (ras_mismatch),
        .ras_mismatch_p(ras_mismatch_p),
        .ras_overflow  (ras_overflow),
        .ras_underflow (ras_underflow),
        .ras_count     (ras_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] mkJal(input int rd);
        return {20'h0, rd[4:0], 7'b1101111};
    endfunction

    function automatic logic [31:0] mkJalr(input int rd, input int rs1);
        return {12'h0, rs1[4:0], 3'b000, rd[4:0], 7'b1100111};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act !== exp) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Return-stack semantics expressed directly on a queue (front = top).
    task automatic modelStep();
        logic [4:0] rd, rs1;
        logic isJal, isJalr, linkRd, linkRs1;
        logic [31:0] dropped;
        mMisP = 1'b0;
        if (ras_clr) begin
            mq.delete();
            mRdy = 1'b1;
            mMis = 1'b0;
            mOvf = 1'b0;
            mUnd = 1'b0;
        end else if (!mRdy) begin
            mRdy = 1'b1;
        end else if (id_adv && branch) begin
            rd      = ins[11:7];
            rs1     = ins[19:15];
            isJal   = (ins[6:0] == 7'h6F);
            isJalr  = (ins[6:0] == 7'h67);
            linkRd  = (rd == 5'd1) || (rd == 5'd5);
            linkRs1 = (rs1 == 5'd1) || (rs1 == 5'd5);
            if (isJalr && linkRd && linkRs1 && rd != rs1) begin
                if (mq.size() == 0) begin
                    mUnd = 1'b1;
                    mq.push_front(next_addr);
                end else begin
                    if (branoff != mq[0]) begin
                        mMis  = 1'b1;
                        mMisP = 1'b1;
                    end
                    mq[0] = next_addr;
                end
            end else if ((isJal || isJalr) && linkRd) begin
                mq.push_front(next_addr);
                if (mq.size() > DEPTH) begin
                    dropped = mq.pop_back();
                    mOvf = 1'b1;
                end
            end else if (isJalr && rd == 5'd0 && linkRs1) begin
                if (mq.size() == 0) begin
                    mUnd = 1'b1;
                end else begin
                    if (branoff != mq[0]) begin
                        mMis  = 1'b1;
                        mMisP = 1'b1;
                    end
                    dropped = mq.pop_front();
                    if (mq.size() > 0) mRdy = 1'b0;
                end
            end
        end
    endtask

    always @(posedge clk or negedge Rst_n) begin
        if (!Rst_n) begin
            mq.delete();
            mRdy  = 1'b1;
            mMis  = 1'b0;
            mMisP = 1'b0;
            mOvf  = 1'b0;
            mUnd  = 1'b0;
        end else begin
            modelStep();
        end
    end

    always @(negedge clk) begin
        checkOutput("cyc_rdy", {31'h0, RAS_rdy}, {31'h0, mRdy});
        checkOutput("cyc_mismatch", {31'h0, ras_mismatch}, {31'h0, mMis});
        checkOutput("cyc_mismatch_p", {31'h0, ras_mismatch_p}, {31'h0, mMisP});
        checkOutput("cyc_overflow", {31'h0, ras_overflow}, {31'h0, mOvf});
        checkOutput("cyc_underflow", {31'h0, ras_underflow}, {31'h0, mUnd});
        checkOutput("cyc_count", {27'h0, ras_count}, 32'(mq.size()));
    end

    // Drives one cycle of inputs, then returns to idle 2 time units after the edge.
    task automatic applyStimulus(input logic [31:0] i, input logic br, input logic adv,
                                 input logic clr, input logic [31:0] na, input logic [31:0] bo);
        ins       = i;
        branch    = br;
        id_adv    = adv;
        ras_clr   = clr;
        next_addr = na;
        branoff   = bo;
        @(posedge clk);
        #2;
        ins     = NOP;
        branch  = 1'b0;
        id_adv  = 1'b0;
        ras_clr = 1'b0;
    endtask

    task automatic doCall(input logic [31:0] addr);
        applyStimulus(mkJal(1), 1'b1, 1'b1, 1'b0, addr, 32'h0);
    endtask

    task automatic doRet(input logic [31:0] target);
        applyStimulus(mkJalr(0, 1), 1'b1, 1'b1, 1'b0, 32'h0, target);
    endtask

    task automatic doClear();
        applyStimulus(NOP, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) applyStimulus(NOP, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #2;
        Rst_n = 1'b1;
        idle(1);
        checkOutput("reset_rdy", {31'h0, RAS_rdy}, 32'h1);
        checkOutput("reset_count", {27'h0, ras_count}, 32'h0);
        checkOutput("reset_flags", {28'h0, ras_mismatch, ras_mismatch_p, ras_overflow, ras_underflow}, 32'h0);

        // Single call / matching return.
        doCall(32'h104);
        checkOutput("call_count", {27'h0, ras_count}, 32'h1);
        doRet(32'h104);
        checkOutput("ret_count", {27'h0, ras_count}, 32'h0);
        checkOutput("ret_rdy", {31'h0, RAS_rdy}, 32'h1);
        checkOutput("ret_mismatch", {31'h0, ras_mismatch}, 32'h0);

        // Nested calls; an event offered during refill must be ignored.
        doCall(32'h10);
        doCall(32'h20);
        doCall(32'h30);
        checkOutput("nest_count3", {27'h0, ras_count}, 32'h3);
        doRet(32'h30);
        checkOutput("nest_refill_rdy", {31'h0, RAS_rdy}, 32'h0);
        checkOutput("nest_count2", {27'h0, ras_count}, 32'h2);
        doCall(32'h99);
        checkOutput("nest_rdy_back", {31'h0, RAS_rdy}, 32'h1);
        checkOutput("nest_ignored", {27'h0, ras_count}, 32'h2);
        doRet(32'h20);
        checkOutput("nest_refill2_rdy", {31'h0, RAS_rdy}, 32'h0);
        idle(1);
        doRet(32'h10);
        checkOutput("nest_last_rdy", {31'h0, RAS_rdy}, 32'h1);
        checkOutput("nest_count0", {27'h0, ras_count}, 32'h0);
        checkOutput("nest_mismatch", {31'h0, ras_mismatch}, 32'h0);

        // Mismatching return; pulse lasts one cycle, flag sticks until clear.
        doCall(32'h40);
        doRet(32'h44);
        checkOutput("mis_pulse", {31'h0, ras_mismatch_p}, 32'h1);
        checkOutput("mis_sticky", {31'h0, ras_mismatch}, 32'h1);
        idle(1);
        checkOutput("mis_pulse_end", {31'h0, ras_mismatch_p}, 32'h0);
        checkOutput("mis_still", {31'h0, ras_mismatch}, 32'h1);
        applyStimulus(mkJal(1), 1'b1, 1'b1, 1'b1, 32'h50, 32'h0);
        checkOutput("clr_mismatch", {31'h0, ras_mismatch}, 32'h0);
        checkOutput("clr_drops_event", {27'h0, ras_count}, 32'h0);

        // Overflow: 17 calls, then 16 returns matching calls 17..2.
        for (int i = 1; i <= 16; i++) doCall(32'h1000 + 32'(i) * 4);
        checkOutput("full_no_ovf", {31'h0, ras_overflow}, 32'h0);
        checkOutput("full_count", {27'h0, ras_count}, 32'd16);
        doCall(32'h1000 + 17 * 4);
        checkOutput("ovf_flag", {31'h0, ras_overflow}, 32'h1);
        checkOutput("ovf_count", {27'h0, ras_count}, 32'd16);
        for (int i = 17; i >= 2; i--) begin
            doRet(32'h1000 + 32'(i) * 4);
            idle(1);
        end
        checkOutput("ovf_drain_count", {27'h0, ras_count}, 32'h0);
        checkOutput("ovf_drain_mismatch", {31'h0, ras_mismatch}, 32'h0);
        doClear();

        // Underflow and non-events.
        doRet(32'h0);
        checkOutput("und_flag", {31'h0, ras_underflow}, 32'h1);
        checkOutput("und_count", {27'h0, ras_count}, 32'h0);
        checkOutput("und_rdy", {31'h0, RAS_rdy}, 32'h1);
        applyStimulus(mkJal(1), 1'b1, 1'b0, 1'b0, 32'h60, 32'h0);
        checkOutput("no_adv", {27'h0, ras_count}, 32'h0);
        applyStimulus(mkJal(1), 1'b0, 1'b1, 1'b0, 32'h60, 32'h0);
        checkOutput("no_branch", {27'h0, ras_count}, 32'h0);
        applyStimulus(mkJal(2), 1'b1, 1'b1, 1'b0, 32'h60, 32'h0);
        checkOutput("non_link_rd", {27'h0, ras_count}, 32'h0);
        doClear();

        // Coroutine swap and push-only jalr x1,0(x1).
        doCall(32'h200);
        doCall(32'h300);
        applyStimulus(mkJalr(1, 5), 1'b1, 1'b1, 1'b0, 32'h500, 32'h300);
        checkOutput("swap_count", {27'h0, ras_count}, 32'h2);
        checkOutput("swap_rdy", {31'h0, RAS_rdy}, 32'h1);
        checkOutput("swap_mismatch", {31'h0, ras_mismatch}, 32'h0);
        doRet(32'h500);
        idle(1);
        doRet(32'h200);
        checkOutput("swap_drain_mismatch", {31'h0, ras_mismatch}, 32'h0);
        applyStimulus(mkJalr(1, 1), 1'b1, 1'b1, 1'b0, 32'h600, 32'h0);
        checkOutput("push_only_count", {27'h0, ras_count}, 32'h1);
        doRet(32'h600);
        checkOutput("push_only_ret", {31'h0, ras_mismatch}, 32'h0);

        // Asynchronous reset in the middle of a refill.
        doCall(32'h700);
        doCall(32'h800);
        doRet(32'h800);
        checkOutput("pre_rst_rdy", {31'h0, RAS_rdy}, 32'h0);
        Rst_n = 1'b0;
        #1;
        checkOutput("async_rst_rdy", {31'h0, RAS_rdy}, 32'h1);
        checkOutput("async_rst_count", {27'h0, ras_count}, 32'h0);
        checkOutput("async_rst_flags", {28'h0, ras_mismatch, ras_mismatch_p, ras_overflow, ras_underflow}, 32'h0);
        #1;
        Rst_n = 1'b1;
        idle(1);
        checkOutput("post_rst_rdy", {31'h0, RAS_rdy}, 32'h1);
        checkOutput("post_rst_count", {27'h0, ras_count}, 32'h0);
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/ra_shadow_stack.md
Name: ra_shadow_stack

Overview:
- Hardware shadow return-address stack sitting beside the core's decode stage, on the rbus side.
- Consumes the IF_ID call/return information the core exports: ins, branch, next_addr, branoff.
- Produces RAS_rdy, which the core ANDs into PC_En to stall fetch while the stack is busy, plus sticky security flags for mismatch, overflow and underflow.
- Calls push the return address. Returns compare their jump target against the stacked value.

Parameters:
- DEPTH, 16: number of stacked return addresses; power of two, at least 2.
- AW, 32: address width.

Ports:
- clk  in  1  system clock.
- Rst_n  in  1  asynchronous active-low reset.
- id_adv  in  1  the IF_ID instruction is consumed this cycle (core PC_En & ~mem_hold). Events are sampled only when this is 1.
- branch  in  1  IF_ID control transfer is taken.
- ins  in  32  IF_ID instruction word.
- next_addr  in  AW  IF_ID_pres_addr+4, the push value.
- branoff  in  AW  resolved jump target of the IF_ID jalr.
- ras_clr  in  1  synchronous clear of the stack and all flags.
- RAS_rdy  out  1  stack can accept an event this cycle.
- ras_mismatch  out  1  sticky: a return target differed from the stacked value.
- ras_mismatch_p  out  1  one-cycle pulse at a mismatch.
- ras_overflow  out  1  sticky: a push was made at full.
- ras_underflow  out  1  sticky: a return was made at empty.
- ras_count  out  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- Decode, combinational, from ins:
  - jal = opcode 1101111.
  - jalr = opcode 1100111.
  - link(r) = r is 1 or 5.
  - call = (jal | jalr) & link(rd = ins[11:7]).
  - ret = jalr & rd==0 & link(rs1 = ins[19:15]).
  - An event fires only when id_adv & branch & RAS_rdy.
- Storage:
  - top register `tos` plus a DEPTH-1 entry circular RAM with one-cycle registered read.
  - Write pointer `wp` wraps modulo DEPTH-1.
- Push (call):
  - tos <= next_addr.
  - If count > 0, RAM[wp] <= tos and wp++.
  - If count < DEPTH, count++. Otherwise ras_overflow <= 1 and count holds; the oldest entry is silently overwritten by the wrap.
  - Zero-latency push; RAS_rdy stays 1.
- Pop (ret):
  - If count==0: ras_underflow <= 1, no compare, state unchanged.
  - Otherwise compare branoff with tos in the same cycle. On inequality, ras_mismatch <= 1 and ras_mismatch_p = 1 for the next cycle.
  - Then count--. If the new count > 0, issue RAM read at wp-1, set wp--, and go to REFILL.
- FSM:
  - IDLE: RAS_rdy=1.
  - IDLE -> REFILL on a pop that leaves count > 0.
  - REFILL: RAS_rdy=0; tos <= RAM read data; -> IDLE next cycle. The refill latency is exactly one cycle.
  - The core's PC_En is low in REFILL, so id_adv is 0 and no event can arrive. Events are ignored in REFILL regardless.
- Call and return in one instruction (jalr with rd and rs1 both link): pop then push, per the RISC-V hint table.
  - If rd != rs1: compare branoff with tos, tos <= next_addr, count unchanged, no refill, RAS_rdy stays 1.
  - If rd == rs1: push only.
- ras_clr:
  - Highest priority below reset.
  - count, wp <= 0; all flags <= 0; FSM <= IDLE.
  - An event in the same cycle is dropped.
- Reset values: RAS_rdy=1, FSM=IDLE, count=0, wp=0, tos=0, every flag and ras_mismatch_p = 0. RAM contents are not reset.
- Reset mid-REFILL returns to IDLE immediately; the outstanding read is discarded.
- The stack never stalls the core except in REFILL. The flags are reporting only; the trap decision belongs to the CSR block.

Decomposition:
- Shared package ras_pkg holds:
  - opcode constants OP_JAL, OP_JALR;
  - link-register constants REG_RA=1, REG_T0=5;
  - typedef ras_state_e {RAS_IDLE, RAS_REFILL};
  - function is_link(r).
- One sub-module, ras_ram: simple dual-port DEPTH-1 x AW RAM, one write port, registered read port, inferred as distributed or block RAM.

Test Plan:
- Reset then call (jal x1) with next_addr=0x104, then ret (jalr x0,0(x1)) with branoff=0x104 -> count 1->0, no flags, RAS_rdy stays 1.
- Nested calls with next_addr 0x10, 0x20, 0x30, then three rets targeting 0x30, 0x20, 0x10 -> RAS_rdy low exactly one cycle after each of the first two rets, count ends 0, no mismatch.
- Call 0x40, then ret with branoff=0x44 -> ras_mismatch_p high one cycle, ras_mismatch sticks until ras_clr.
- 17 calls with DEPTH=16 -> ras_overflow=1 at the 17th, count stays 16. The subsequent 16 rets match calls 17..2.
- Ret on an empty stack -> ras_underflow=1, count 0, RAS_rdy stays 1. An event held with id_adv=0 -> no state change.
- Pop that triggers a refill, then assert Rst_n low during REFILL -> all outputs take reset values asynchronously, RAS_rdy=1 after release.
